// File: rtl/dpram_pkg.sv
// Shared types and helpers for the true dual-port byte-enable RAM.
// Contents:
//   dpram_st_t  - clear-sweep FSM state
//   BYTES       - byte lanes of the default word width
//   be_merge    - merge new bytes into an old word under a byte-enable mask
//   byte_parity - per-byte even-parity bits of a word
// Helpers work on a MAX_DW-bit container. Callers zero-extend their operands
// into it and truncate the result back to their own width.
package dpram_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} dpram_st_t;

  localparam int DATA_WIDTH_DFLT = 16;
  localparam int BYTES           = DATA_WIDTH_DFLT / 8;
  localparam int MAX_DW          = 64;
  localparam int MAX_BYTES       = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0]    old_w,
                                                 input logic [MAX_DW-1:0]    new_w,
                                                 input logic [MAX_BYTES-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DW-1:0] w);
    logic [MAX_BYTES-1:0] p;
    for (int i = 0; i < MAX_BYTES; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return pipeline for one RAM port. It has LAT register stages, where
// LAT is 1 or 2. Any other value behaves as 1.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   v_in, d_in read accepted this cycle, and the word to return
//   qv, q      read-valid strobe and returned word
// The data stages load only when their valid bit is set, so q holds its last
// value between strobes.
module dpram_rd_pipe #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         qv,
  output logic [W-1:0] q
);

  logic         v1;
  logic [W-1:0] d1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= v_in;
      if (v_in) d1 <= d_in;
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic         v2;
      logic [W-1:0] d2;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign qv = v2;
      assign q  = d2;
    end else begin : g_lat1
      assign qv = v1;
      assign q  = d1;
    end
  endgenerate

endmodule

// File: rtl/true_dpram_be.sv
// True dual-port RAM with per-byte write enables, single clock.
// The clear sweep writes CLR_VALUE to every word after reset or on clr_req.
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   clr_req, busy         clear-sweep request and sweep-in-progress flag
//   a_a/d_a/be_a/r_a      port A: address, write data, byte enables, read request
//   a_b/d_b/be_b/r_b      port B: the same set of inputs
//   q_a/qv_a, q_b/qv_b    read data and read-valid strobe for each port
//   coll                  same-address collision flag, registered, one cycle
//   perr_a, perr_b        per-byte parity error, valid with qv (DPRAM_PARITY_EN only)
// Macro DPRAM_PARITY_EN adds one even-parity bit per stored byte and the
// perr outputs.
module true_dpram_be
  import dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = BYTES * 8,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic [ADDR_WIDTH-1:0]   a_a,
  input  logic [ADDR_WIDTH-1:0]   a_b,
  input  logic [DATA_WIDTH-1:0]   d_a,
  input  logic [DATA_WIDTH-1:0]   d_b,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic                    r_a,
  input  logic                    r_b,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    qv_a,
  output logic                    qv_b,
`ifdef DPRAM_PARITY_EN
  output logic [DATA_WIDTH/8-1:0] perr_a,
  output logic [DATA_WIDTH/8-1:0] perr_b,
`endif
  output logic                    coll
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  dpram_st_t             state;
  logic [ADDR_WIDTH-1:0] clr_addr;

  // One counter walks every address. On the last address the sweep still
  // writes that word, then returns to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Collision detection and A-over-B priority. On a same-address double
  // write, B loses every byte that A also enables, so the two port blocks
  // never write the same byte lane.
  logic          wr_a, wr_b, rd_a, rd_b, same, coll_nxt;
  logic [NB-1:0] be_b_eff;

  always_comb begin
    wr_a     = !busy && (|be_a);
    wr_b     = !busy && (|be_b);
    rd_a     = !busy && r_a;
    rd_b     = !busy && r_b;
    same     = (a_a == a_b);
    be_b_eff = wr_b ? be_b : '0;
    if (same && wr_a) be_b_eff = be_b_eff & ~be_a;
    coll_nxt = same && (wr_a || wr_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) coll <= 1'b0;
    else      coll <= coll_nxt;
  end

  // Storage has one write process per port. The clear sweep uses the port A
  // process, because both ports are blocked while busy.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= CLR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be_a[i]) mem[a_a][8*i +: 8] <= d_a[8*i +: 8];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be_b_eff[i]) mem[a_b][8*i +: 8] <= d_b[8*i +: 8];
    end
  end

  // Each port reads its own write first. The other port's write lands at
  // the same edge, so that port sees the old word.
  logic [DATA_WIDTH-1:0] rdat_a, rdat_b;

  always_comb begin
    rdat_a = DATA_WIDTH'(be_merge(MAX_DW'(mem[a_a]), MAX_DW'(d_a), MAX_BYTES'(be_a)));
    rdat_b = DATA_WIDTH'(be_merge(MAX_DW'(mem[a_b]), MAX_DW'(d_b), MAX_BYTES'(be_b)));
  end

`ifdef DPRAM_PARITY_EN
  localparam logic [NB-1:0] CLR_PAR = NB'(byte_parity(MAX_DW'(CLR_VALUE)));

  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] pd_a, pd_b, pin_a, pin_b;

  always_comb begin
    pd_a  = NB'(byte_parity(MAX_DW'(d_a)));
    pd_b  = NB'(byte_parity(MAX_DW'(d_b)));
    // Bytes freshly written by the reading port carry the new data, so they cannot mismatch.
    pin_a = (NB'(byte_parity(MAX_DW'(mem[a_a]))) ^ par[a_a]) & ~be_a;
    pin_b = (NB'(byte_parity(MAX_DW'(mem[a_b]))) ^ par[a_b]) & ~be_b;
  end

  always @(posedge clk) begin
    if (busy) begin
      par[clr_addr] <= CLR_PAR;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be_a[i]) par[a_a][i] <= pd_a[i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be_b_eff[i]) par[a_b][i] <= pd_b[i];
    end
  end

  logic [DATA_WIDTH+NB-1:0] pq_a, pq_b;

  dpram_rd_pipe #(.W(DATA_WIDTH + NB), .LAT(RD_LATENCY)) u_pipe_a (
    .clk (clk), .rst (rst), .v_in (rd_a), .d_in ({pin_a, rdat_a}), .qv (qv_a), .q (pq_a)
  );
  dpram_rd_pipe #(.W(DATA_WIDTH + NB), .LAT(RD_LATENCY)) u_pipe_b (
    .clk (clk), .rst (rst), .v_in (rd_b), .d_in ({pin_b, rdat_b}), .qv (qv_b), .q (pq_b)
  );

  assign {perr_a, q_a} = pq_a;
  assign {perr_b, q_b} = pq_b;
`else
  dpram_rd_pipe #(.W(DATA_WIDTH), .LAT(RD_LATENCY)) u_pipe_a (
    .clk (clk), .rst (rst), .v_in (rd_a), .d_in (rdat_a), .qv (qv_a), .q (q_a)
  );
  dpram_rd_pipe #(.W(DATA_WIDTH), .LAT(RD_LATENCY)) u_pipe_b (
    .clk (clk), .rst (rst), .v_in (rd_b), .d_in (rdat_b), .qv (qv_b), .q (q_b)
  );
`endif

endmodule

// File: tb/tb_true_dpram_be.sv
module tb_true_dpram_be;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NB    = 2;
  localparam int LAT   = 2;
  localparam int NVEC  = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_req;
  logic          busy;
  logic [AW-1:0] a_a, a_b;
  logic [DW-1:0] d_a, d_b;
  logic [NB-1:0] be_a, be_b;
  logic          r_a, r_b;
  logic [DW-1:0] q_a, q_b;
  logic          qv_a, qv_b;
  logic          coll;
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] perr_a, perr_b;
`endif

  true_dpram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .CLR_VALUE(16'h0000)) dut (
    .clk (clk), .rst (rst), .clr_req (clr_req), .busy (busy),
    .a_a (a_a), .a_b (a_b), .d_a (d_a), .d_b (d_b), .be_a (be_a), .be_b (be_b),
    .r_a (r_a), .r_b (r_b), .q_a (q_a), .q_b (q_b), .qv_a (qv_a), .qv_b (qv_b),
`ifdef DPRAM_PARITY_EN
    .perr_a (perr_a), .perr_b (perr_b),
`endif
    .coll (coll)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] aa; logic [DW-1:0] da; logic [NB-1:0] bea; logic ra;
    logic [AW-1:0] ab; logic [DW-1:0] db; logic [NB-1:0] beb; logic rb;
    logic [DW-1:0] eqa; logic [DW-1:0] eqb; logic ecoll;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] perr;
    int            due;
  } exp_t;

  exp_t qa_q[$];
  exp_t qb_q[$];
  exp_t ea, eb;
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mkv(int aa, int da, int bea, int ra, int ab, int db, int beb, int rb,
                               int eqa, int eqb, int ec);
    vec_t v;
    v.aa = AW'(aa); v.da = DW'(da); v.bea = NB'(bea); v.ra = 1'(ra);
    v.ab = AW'(ab); v.db = DW'(db); v.beb = NB'(beb); v.rb = 1'(rb);
    v.eqa = DW'(eqa); v.eqb = DW'(eqb); v.ecoll = 1'(ec);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_idle();
    clr_req = 1'b0;
    a_a = '0; d_a = '0; be_a = '0; r_a = 1'b0;
    a_b = '0; d_b = '0; be_b = '0; r_b = 1'b0;
  endtask

  task automatic push_a(input logic [DW-1:0] d, input logic [NB-1:0] p);
    exp_t e;
    e.data = d; e.perr = p; e.due = cyc + LAT;
    qa_q.push_back(e);
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    exp_t e;
    e.data = d; e.perr = '0; e.due = cyc + LAT;
    qb_q.push_back(e);
  endtask

  // Drive one cycle of requests. If accept is set, queue the expected read returns.
  task automatic apply(input vec_t v, input bit accept);
    a_a = v.aa; d_a = v.da; be_a = v.bea; r_a = v.ra;
    a_b = v.ab; d_b = v.db; be_b = v.beb; r_b = v.rb;
    if (accept && v.ra) push_a(v.eqa, '0);
    if (accept && v.rb) push_b(v.eqb);
    @(negedge clk);
    set_idle();
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Scoreboard: each strobe pops the oldest expectation for its port and must arrive on its due cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (qv_a) begin
        checks++;
        if (qa_q.size() == 0) begin
          errors++;
          $display("FAIL qv_a_unexpected q_a=%h cycle=%0d", q_a, cyc);
        end else begin
          ea = qa_q.pop_front();
          if (q_a !== ea.data || cyc != ea.due) begin
            errors++;
            $display("FAIL rd_a actual=%h@%0d required=%h@%0d", q_a, cyc, ea.data, ea.due);
          end
`ifdef DPRAM_PARITY_EN
          else if (perr_a !== ea.perr) begin
            errors++;
            $display("FAIL perr_a actual=%b required=%b", perr_a, ea.perr);
          end
`endif
        end
      end else if (qa_q.size() != 0 && qa_q[0].due < cyc) begin
        checks++;
        errors++;
        ea = qa_q.pop_front();
        $display("FAIL qv_a_missing actual=0 required=1 due=%0d", ea.due);
      end
      if (qv_b) begin
        checks++;
        if (qb_q.size() == 0) begin
          errors++;
          $display("FAIL qv_b_unexpected q_b=%h cycle=%0d", q_b, cyc);
        end else begin
          eb = qb_q.pop_front();
          if (q_b !== eb.data || cyc != eb.due) begin
            errors++;
            $display("FAIL rd_b actual=%h@%0d required=%h@%0d", q_b, cyc, eb.data, eb.due);
          end
        end
      end else if (qb_q.size() != 0 && qb_q[0].due < cyc) begin
        checks++;
        errors++;
        eb = qb_q.pop_front();
        $display("FAIL qv_b_missing actual=0 required=1 due=%0d", eb.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //                aa  da        bea ra ab  db        beb rb eqa       eqb       coll
    vecs[0]  = mkv(3,  'h1234, 3,  0, 0,  0,      0,  0, 0,       0,       0);
    vecs[1]  = mkv(3,  'hABCD, 1,  0, 0,  0,      0,  0, 0,       0,       0);
    vecs[2]  = mkv(3,  0,      0,  1, 0,  0,      0,  0, 'h12CD,  0,       0);
    vecs[3]  = mkv(5,  'hAAAA, 2,  0, 5,  'h5555, 3,  0, 0,       0,       1);
    vecs[4]  = mkv(5,  0,      0,  1, 5,  0,      0,  1, 'hAA55,  'hAA55,  0);
    vecs[5]  = mkv(7,  'h0F0F, 3,  0, 7,  0,      0,  1, 0,       'h0000,  1);
    vecs[6]  = mkv(0,  0,      0,  0, 7,  0,      0,  1, 0,       'h0F0F,  0);
    vecs[7]  = mkv(2,  'hBEEF, 3,  1, 9,  'h1177, 1,  0, 'hBEEF,  0,       0);
    vecs[8]  = mkv(9,  0,      0,  1, 2,  0,      0,  1, 'h0077,  'hBEEF,  0);
    vecs[9]  = mkv(15, 0,      0,  1, 15, 'hFFFF, 2,  0, 'h0000,  0,       1);
    vecs[10] = mkv(15, 0,      0,  1, 15, 0,      0,  1, 'hFF00,  'hFF00,  0);
    vecs[11] = mkv(3,  'hFFFF, 0,  0, 3,  0,      0,  1, 0,       'h12CD,  0);
    vecs[12] = mkv(4,  'h1299, 2,  1, 0,  0,      0,  0, 'h1200,  0,       0);
    vecs[13] = mkv(4,  0,      0,  1, 4,  'h0034, 1,  0, 'h1200,  0,       1);
    vecs[14] = mkv(0,  0,      0,  0, 4,  0,      0,  1, 0,       'h1234,  0);

    set_idle();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_q_a", 32'(q_a), 32'd0);
    check("rst_q_b", 32'(q_b), 32'd0);
    check("rst_qv", 32'({qv_a, qv_b}), 32'd0);
    check("rst_coll", 32'(coll), 32'd0);
    rst = 1'b1;
    count_busy(n);
    check("busy_len_reset", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) apply(mkv(i, 0, 0, 1, 15 - i, 0, 0, 1, 0, 0, 0), 1'b1);
    repeat (4) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], 1'b1);
      check($sformatf("coll_v%0d", i), 32'(coll), 32'(vecs[i].ecoll));
    end
    repeat (4) @(negedge clk);

    // Clear with traffic still applied. Every request is dropped, and a second clr_req is ignored.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    check("clr_busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      a_a = 4'd1; d_a = 16'hFFFF; be_a = 2'b11; r_a = 1'b1;
      a_b = 4'd1; d_b = 16'hEEEE; be_b = 2'b11; r_b = 1'b1;
      clr_req = (n == 5);
      @(negedge clk);
      n++;
      check("busy_qv", 32'({qv_a, qv_b}), 32'd0);
      check("busy_coll", 32'(coll), 32'd0);
    end
    set_idle();
    check("busy_len_clr", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) apply(mkv(i, 0, 0, 1, i, 0, 0, 1, 0, 0, 0), 1'b1);
    repeat (4) @(negedge clk);

`ifdef DPRAM_PARITY_EN
    dut.mem[4] = dut.mem[4] ^ 16'h0100;
    a_a = 4'd4; r_a = 1'b1;
    push_a(16'h0100, 2'b10);
    @(negedge clk);
    set_idle();
    repeat (4) @(negedge clk);
`endif

    // Reset partway through a sweep restarts the sweep with the full length.
    apply(mkv(6, 'h6666, 3, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    apply(mkv(6, 0, 0, 1, 6, 0, 0, 1, 'h6666, 'h6666, 0), 1'b1);
    repeat (4) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_q_a", 32'(q_a), 32'd0);
    check("midrst_q_b", 32'(q_b), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    check("busy_len_midrst", 32'(n), 32'd16);
    apply(mkv(9, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), 1'b1);

    repeat (6) @(negedge clk);
    check("drain_a", 32'(qa_q.size()), 32'd0);
    check("drain_b", 32'(qb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
